// File: rtl/mem_access_unit.sv
// Purpose : single-outstanding load/store front end for the 64 KiB byte-addressed data SRAM.
// Latency : stores/errors respond 1 cycle after acceptance; loads respond LOAD_LATENCY cycles after.
// Backpr. : req_ready is high only in IDLE (and not in reset); one request in flight at a time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_we, req_funct3, req_addr, req_wdata qualify it
//   resp_valid/resp_err/rdata     one-cycle response pulse, error flag, extended load data
//   sram_w_en/address/write_data  SRAM write port and shared address; sram_read_data is combinational
//   ld_count, st_count            saturating counts of completed legal loads/stores
module mem_access_unit #(
   parameter int ADDR_W       = 16,
   parameter int LOAD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [3:0]        sram_w_en,
   output logic [ADDR_W-1:0] sram_address,
   output logic [31:0]       sram_write_data,
   input  logic [31:0]       sram_read_data,
   output logic [15:0]       ld_count,
   output logic [15:0]       st_count
);

   typedef enum logic [1:0] {IDLE, LWAIT, RESP} state_t;

   state_t            state, state_d;
   logic [3:0]        lat_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;

   logic              legal;
   logic [1:0]        size_m1;
   logic [ADDR_W:0]   addr_end;
   logic              req_ok;
   logic              accept;
   logic              st_done;
   logic              ld_done;
   logic [2:0]        ld_f3;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'b0, d[7:0]};
         3'b101:  return {16'b0, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Size/legality decode of the incoming request.
   always_comb begin
      size_m1 = 2'd0;
      legal   = 1'b0;
      case (req_funct3)
         3'b000: begin size_m1 = 2'd0; legal = 1'b1;     end
         3'b001: begin size_m1 = 2'd1; legal = 1'b1;     end
         3'b010: begin size_m1 = 2'd3; legal = 1'b1;     end
         3'b100: begin size_m1 = 2'd0; legal = !req_we;  end
         3'b101: begin size_m1 = 2'd1; legal = !req_we;  end
         default: begin size_m1 = 2'd0; legal = 1'b0;    end
      endcase
   end

   // One extra bit catches an access whose last byte lies past the top of the address space.
   assign addr_end = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
   assign req_ok   = legal && !addr_end[ADDR_W];

   // For a single-cycle load the result is sampled in the acceptance cycle, so the live funct3 applies.
   assign ld_f3           = (state == IDLE) ? req_funct3 : funct3_q;
   assign sram_address    = (state == IDLE) ? req_addr : addr_q;
   assign sram_write_data = req_wdata;

   always_comb begin
      state_d   = state;
      req_ready = 1'b0;
      accept    = 1'b0;
      st_done   = 1'b0;
      ld_done   = 1'b0;
      sram_w_en = 4'b0000;
      case (state)
         IDLE: begin
            req_ready = !rst;
            accept    = req_valid && !rst;
            if (accept) begin
               if (!req_ok || req_we) begin
                  state_d = RESP;
               end else if (LOAD_LATENCY > 1) begin
                  state_d = LWAIT;
               end else begin
                  state_d = RESP;
                  ld_done = 1'b1;
               end
               if (req_ok && req_we) begin
                  st_done = 1'b1;
                  case (size_m1)
                     2'd0:    sram_w_en = 4'b0001;
                     2'd1:    sram_w_en = 4'b0011;
                     default: sram_w_en = 4'b1111;
                  endcase
               end
            end
         end
         LWAIT: begin
            // Counter value 1 here becomes 0 at this edge: RESP is entered now.
            if (lat_cnt == 4'd1) begin
               state_d = RESP;
               ld_done = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (rst) begin
         sram_w_en = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lat_cnt    <= 4'd0;
         addr_q     <= '0;
         funct3_q   <= 3'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         ld_count   <= 16'd0;
         st_count   <= 16'd0;
      end else begin
         state      <= state_d;
         resp_valid <= (state_d == RESP);
         resp_err   <= accept && !req_ok;
         resp_rdata <= ld_done ? extend(ld_f3, sram_read_data) : 32'd0;
         if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            lat_cnt  <= 4'(LOAD_LATENCY - 1);
         end else if (state == LWAIT) begin
            lat_cnt  <= lat_cnt - 4'd1;
         end
         if (st_done && st_count != 16'hFFFF) st_count <= st_count + 16'd1;
         if (ld_done && ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the pipeline MEM stage and the byte-addressed 64 KiB data SRAM (combinational read, posedge write, w_en codes 0001/0011/1111).
- Accepts one load/store request at a time over a valid/ready handshake and decodes RISC-V funct3 into SRAM w_en.
- Returns loads with sign/zero extension after a fixed latency; flags illegal size encodings and address wrap-around.
- Keeps saturating load/store counters.

Parameters:
- ADDR_W, 16, byte address width; must equal the SRAM address width.
- LOAD_LATENCY, 1, cycles from load acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V size/sign field
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: request was rejected
- sram_w_en  out  4  SRAM byte-write enable
- sram_address  out  ADDR_W  SRAM address
- sram_write_data  out  32  SRAM write data
- sram_read_data  in  32  SRAM combinational read data
- ld_count  out  16  completed legal loads, saturating
- st_count  out  16  completed legal stores, saturating

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, ld_count=0, st_count=0, latency counter=0.
  - sram_w_en is forced to 0 combinationally while rst=1.
  - Reset mid-operation abandons the request with no response.
- FSM states: IDLE, LWAIT, RESP.
  - req_ready=1 only in IDLE and not in rst.
  - A request is accepted when req_valid && req_ready.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Any other code is illegal.
- Size: 1/2/4 bytes. A wrap error occurs when req_addr + size - 1 > 2^ADDR_W - 1.
- Error request (illegal code or wrap):
  - no SRAM write;
  - next cycle RESP with resp_valid=1, resp_err=1, resp_rdata=0;
  - no counter change.
- Legal store:
  - in the acceptance cycle sram_w_en=0001/0011/1111 for SB/SH/SW, sram_address=req_addr, sram_write_data=req_wdata unmodified;
  - the SRAM commits at that posedge;
  - next cycle RESP with resp_valid=1, resp_err=0, resp_rdata=0; st_count increments.
- Legal load:
  - latch addr and funct3, load the counter with LOAD_LATENCY-1;
  - go to LWAIT if LOAD_LATENCY>1, else go to RESP.
  - In LWAIT, decrement the counter; go to RESP when it reaches 0.
  - On entry to RESP, sample sram_read_data (latched addr driven) and register the result.
  - Extension:
    - LB: sign-extend [7:0]
    - LBU: zero-extend [7:0]
    - LH: sign-extend [15:0]
    - LHU: zero-extend [15:0]
    - LW: all 32 bits
  - resp_valid is high exactly at cycle T+LOAD_LATENCY for acceptance at T; ld_count increments.
- sram_address:
  - equals req_addr in IDLE;
  - otherwise equals the latched address.
- sram_w_en is 0 in every cycle other than a legal-store acceptance cycle.
- RESP lasts one cycle, then goes to IDLE.
  - Maximum throughput is one request per 2 cycles (stores) or LOAD_LATENCY+1 cycles (loads).
- Counters saturate at 0xFFFF with no wrap.
- Request inputs are ignored when req_ready=0.

Test Plan:
- Reset, then SW addr=0x0010 wdata=0xDEADBEEF.
  - Acceptance cycle: sram_w_en=1111.
  - Next cycle: resp_valid=1, resp_err=0, st_count=1.
  - Then LW 0x0010: resp_rdata=0xDEADBEEF at T+1.
- SB 0x0020 data 0x000000F0, then LB 0x0020 → resp_rdata=0xFFFFFFF0; LBU 0x0020 → 0x000000F0.
- SH 0x0030 data 0x8001, then LH → 0xFFFF8001, LHU → 0x00008001, ld_count=2.
- LW 0xFFFE → resp_err=1, resp_rdata=0, no write. SH 0xFFFF → resp_err=1, sram_w_en stays 0000.
- funct3=011 load, and store with funct3=100 → resp_err=1 each; ld_count and st_count unchanged.
- LOAD_LATENCY=3:
  - LW accepted at T → resp_valid only at T+3; req_ready=0 at T+1..T+3.
  - req_valid held high in that window is not accepted.
  - rst asserted at T+2 → no response, counters 0, req_ready=1 after reset.
